// File: rtl/banked_memory_if.sv
// Request/response bundle for the banked memory wrapper.
// A request is taken on any rising edge where wr_en or rd_en is high; there is no
// back-pressure, so requests that cannot be served are dropped and flagged on err.
interface banked_memory_if #(
   parameter int WIDTH      = 8,
   parameter int ADD_WIDTH  = 7,
   parameter int MEM_NUMBER = 8
);
   logic [ADD_WIDTH-1:0]        addr;
   logic [WIDTH*MEM_NUMBER-1:0] wdata;
   logic                        wr_en;
   logic [MEM_NUMBER-1:0]       wr_mask;
   logic                        rd_en;
   logic                        clr_req;
   logic [WIDTH*MEM_NUMBER-1:0] rdata;
   logic                        rd_valid;
   logic                        busy;
   logic                        err;
   logic                        fsm_state;

   modport master (
      output addr, wdata, wr_en, wr_mask, rd_en, clr_req,
      input  rdata, rd_valid, busy, err, fsm_state
   );

   modport slave (
      input  addr, wdata, wr_en, wr_mask, rd_en, clr_req,
      output rdata, rd_valid, busy, err, fsm_state
   );
endinterface

// File: rtl/banked_memory_wrapper.sv
// MEM_NUMBER parallel DEPTH x WIDTH banks sharing one address, with per-lane write
// mask, registered read-first reads, and a zeroing sweep after reset or on request.
module banked_memory_wrapper #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 128,
   parameter int ADD_WIDTH     = 7,
   parameter int MEM_NUMBER    = 8,
   parameter int INIT_ON_RESET = 1
) (
   input logic            clk,
   input logic            rst,
   banked_memory_if.slave bus
);

   localparam int DW = WIDTH * MEM_NUMBER;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t               state;
   logic [ADD_WIDTH-1:0] cnt;
   logic                 init_pend;
   logic [DW-1:0]        rdata_q;
   logic                 rd_valid_q;
   logic                 busy_q;
   logic                 err_q;

   logic [DW-1:0]         rd_bus;
   logic                  in_range;
   logic                  req;
   logic                  start;
   logic [MEM_NUMBER-1:0] lane_we;
   logic [ADD_WIDTH-1:0]  wr_addr;

   assign in_range = (32'(bus.addr) < 32'(DEPTH));
   assign req      = bus.wr_en | bus.rd_en;
   assign start    = (state == IDLE) & (bus.clr_req | init_pend);
   assign wr_addr  = (state == CLEAR) ? cnt : bus.addr;

   // Array writes are gated by rst so an aborted sweep leaves no stray write behind.
   always_comb begin
      lane_we = '0;
      if (!rst) begin
         if (state == CLEAR)
            lane_we = '1;
         else if (!start && bus.wr_en && in_range)
            lane_we = bus.wr_mask;
      end
   end

   for (genvar g = 0; g < MEM_NUMBER; g++) begin : g_bank
      logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (lane_we[g])
            mem[wr_addr] <= (state == CLEAR) ? '0 : bus.wdata[g*WIDTH +: WIDTH];
      end

      assign rd_bus[g*WIDTH +: WIDTH] = in_range ? mem[bus.addr] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         init_pend  <= (INIT_ON_RESET != 0);
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  busy_q    <= 1'b1;
                  cnt       <= '0;
                  init_pend <= 1'b0;
                  err_q     <= req;
               end else begin
                  if (bus.rd_en) begin
                     rd_valid_q <= 1'b1;
                     rdata_q    <= rd_bus;
                  end
                  err_q <= req & ~in_range;
               end
            end
            CLEAR: begin
               err_q <= req;
               if (cnt == ADD_WIDTH'(DEPTH - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_banked_memory_wrapper.sv
// Bench for banked_memory_wrapper: a 128-deep instance for the main features and a
// 100-deep instance for out-of-range addressing, both checked through read scoreboards.
module tb_banked_memory_wrapper;

   logic clk;
   logic rst;

   int n_checks;
   int n_fail;

   logic [63:0] exp_q1[$];
   logic [63:0] exp_q2[$];

   banked_memory_if #(.WIDTH(8), .ADD_WIDTH(7), .MEM_NUMBER(8)) bus1 ();
   banked_memory_if #(.WIDTH(8), .ADD_WIDTH(7), .MEM_NUMBER(8)) bus2 ();

   banked_memory_wrapper #(
      .WIDTH(8), .DEPTH(128), .ADD_WIDTH(7), .MEM_NUMBER(8), .INIT_ON_RESET(1)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   banked_memory_wrapper #(
      .WIDTH(8), .DEPTH(100), .ADD_WIDTH(7), .MEM_NUMBER(8), .INIT_ON_RESET(1)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboards
   always @(negedge clk) begin
      if (!rst && bus1.rd_valid) begin
         n_checks++;
         if (exp_q1.size() == 0) begin
            n_fail++;
            $display("FAIL sb1_unexpected: rd_valid with rdata=%h, none expected", bus1.rdata);
         end else begin
            logic [63:0] e;
            e = exp_q1.pop_front();
            if (bus1.rdata !== e) begin
               n_fail++;
               $display("FAIL sb1_rdata: got %h expected %h", bus1.rdata, e);
            end
         end
      end
      if (!rst && bus2.rd_valid) begin
         n_checks++;
         if (exp_q2.size() == 0) begin
            n_fail++;
            $display("FAIL sb2_unexpected: rd_valid with rdata=%h, none expected", bus2.rdata);
         end else begin
            logic [63:0] e;
            e = exp_q2.pop_front();
            if (bus2.rdata !== e) begin
               n_fail++;
               $display("FAIL sb2_rdata: got %h expected %h", bus2.rdata, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus1.addr = '0; bus1.wdata = '0; bus1.wr_en = 0; bus1.wr_mask = '0;
      bus1.rd_en = 0; bus1.clr_req = 0;
      bus2.addr = '0; bus2.wdata = '0; bus2.wr_en = 0; bus2.wr_mask = '0;
      bus2.rd_en = 0; bus2.clr_req = 0;
   endtask

   task automatic write1(input logic [6:0] a, input logic [63:0] d, input logic [7:0] m);
      bus1.addr = a; bus1.wdata = d; bus1.wr_mask = m; bus1.wr_en = 1;
      tick();
      bus1.wr_en = 0;
   endtask

   task automatic read1(input logic [6:0] a, input logic [63:0] e);
      bus1.addr = a; bus1.rd_en = 1;
      exp_q1.push_back(e);
      tick();
      bus1.rd_en = 0;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Counts busy cycles of both instances starting at the first edge after rst release.
   task automatic count_sweep(input string name);
      int c1, c2, guard;
      check({name, "_busy_before_edge"}, 64'(bus1.busy), 64'd0);
      tick();
      c1 = 0; c2 = 0; guard = 0;
      while ((bus1.busy || bus2.busy) && guard < 1000) begin
         if (bus1.busy) c1++;
         if (bus2.busy) c2++;
         guard++;
         tick();
      end
      check({name, "_busy_cycles_dut1"}, 64'(c1), 64'd128);
      check({name, "_busy_cycles_dut2"}, 64'(c2), 64'd100);
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      repeat (3) tick();
      check("reset_rdata", bus1.rdata, 64'h0);
      check("reset_rd_valid", 64'(bus1.rd_valid), 64'd0);
      check("reset_busy", 64'(bus1.busy), 64'd0);
      check("reset_err", 64'(bus1.err), 64'd0);
      rst = 0;
      count_sweep("init");
      read1(7'd5, 64'h0);
      check("init_rd_valid_pulse", 64'(bus1.rd_valid), 64'd1);
      tick();
      check("init_rd_valid_drop", 64'(bus1.rd_valid), 64'd0);
   endtask

   task automatic test_masked_write();
      write1(7'd3, 64'h0807060504030201, 8'hFF);
      write1(7'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      read1(7'd3, 64'h08070605FFFFFFFF);
      repeat (3) tick();
      check("rdata_hold", bus1.rdata, 64'h08070605FFFFFFFF);
      check("rdata_hold_valid", 64'(bus1.rd_valid), 64'd0);
   endtask

   task automatic test_read_first();
      bus1.addr = 7'd3; bus1.wdata = 64'h1111111111111111; bus1.wr_mask = 8'hFF;
      bus1.wr_en = 1; bus1.rd_en = 1;
      exp_q1.push_back(64'h08070605FFFFFFFF);
      tick();
      bus1.wr_en = 0; bus1.rd_en = 0;
      read1(7'd3, 64'h1111111111111111);
      tick();
   endtask

   task automatic test_out_of_range();
      bus2.addr = 7'd5; bus2.wdata = 64'hA5A5_1234_5678_9ABC; bus2.wr_mask = 8'hFF;
      bus2.wr_en = 1;
      tick();
      bus2.wr_en = 0;
      check("oor_inrange_err", 64'(bus2.err), 64'd0);
      bus2.addr = 7'd120; bus2.wdata = 64'hFFFFFFFFFFFFFFFF;
      bus2.wr_en = 1; bus2.rd_en = 1;
      exp_q2.push_back(64'h0);
      tick();
      bus2.wr_en = 0; bus2.rd_en = 0;
      check("oor_err_pulse", 64'(bus2.err), 64'd1);
      check("oor_rd_valid", 64'(bus2.rd_valid), 64'd1);
      tick();
      check("oor_err_drop", 64'(bus2.err), 64'd0);
      bus2.addr = 7'd5; bus2.rd_en = 1;
      exp_q2.push_back(64'hA5A5_1234_5678_9ABC);
      tick();
      bus2.rd_en = 0;
      bus2.addr = 7'd99; bus2.rd_en = 1;
      exp_q2.push_back(64'h0);
      tick();
      bus2.rd_en = 0;
      check("oor_last_word_err", 64'(bus2.err), 64'd0);
      tick();
   endtask

   task automatic test_back_to_back();
      logic [63:0] model [8];
      logic [63:0] d, lm;
      logic [7:0]  m;
      for (int i = 0; i < 8; i++) begin
         d = {$urandom, $urandom};
         m = 8'($urandom_range(1, 255));
         lm = '0;
         for (int l = 0; l < 8; l++)
            if (m[l]) lm[l*8 +: 8] = 8'hFF;
         model[i] = d & lm;
         bus1.addr = 7'(10 + i); bus1.wdata = d; bus1.wr_mask = m; bus1.wr_en = 1;
         tick();
      end
      bus1.wr_en = 0;
      for (int i = 0; i < 8; i++) begin
         bus1.addr = 7'(17 - i); bus1.rd_en = 1;
         exp_q1.push_back(model[7 - i]);
         tick();
         check("b2b_err", 64'(bus1.err), 64'd0);
      end
      bus1.rd_en = 0;
      tick();
   endtask

   task automatic test_clear_abort();
      bus1.clr_req = 1; bus1.rd_en = 1; bus1.addr = 7'd3;
      tick();
      bus1.clr_req = 0; bus1.rd_en = 0;
      check("clr_prio_busy", 64'(bus1.busy), 64'd1);
      check("clr_prio_err", 64'(bus1.err), 64'd1);
      check("clr_prio_rd_valid", 64'(bus1.rd_valid), 64'd0);
      repeat (10) tick();
      bus1.rd_en = 1;
      tick();
      bus1.rd_en = 0;
      check("busy_drop_err", 64'(bus1.err), 64'd1);
      check("busy_drop_rd_valid", 64'(bus1.rd_valid), 64'd0);
      bus1.clr_req = 1;
      tick();
      bus1.clr_req = 0;
      check("busy_clr_no_err", 64'(bus1.err), 64'd0);
      check("busy_state", 64'(bus1.fsm_state), 64'd1);
      repeat (38) tick();
      #3 rst = 1;
      #1;
      check("abort_rdata", bus1.rdata, 64'h0);
      check("abort_busy", 64'(bus1.busy), 64'd0);
      check("abort_err", 64'(bus1.err), 64'd0);
      check("abort_state", 64'(bus1.fsm_state), 64'd0);
      tick();
      rst = 0;
      count_sweep("restart");
      read1(7'd3, 64'h0);
      read1(7'd127, 64'h0);
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_masked_write();
      test_read_first();
      test_out_of_range();
      test_back_to_back();
      test_clear_abort();
      repeat (2) tick();
      check("sb1_drained", 64'(exp_q1.size()), 64'd0);
      check("sb2_drained", 64'(exp_q2.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/banked_memory_wrapper.md
BANKED_MEMORY_WRAPPER -- requirements
Module: banked_memory_wrapper

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one bank lane.
REQ-002 SHALL have parameter DEPTH, default 128, words per bank.
REQ-003 SHALL have parameter ADD_WIDTH, default 7, address width; DEPTH <= 2**ADD_WIDTH.
REQ-004 SHALL have parameter MEM_NUMBER, default 8, number of banks (lanes).
REQ-005 SHALL have parameter INIT_ON_RESET, default 1, 1 = run a clear sweep after reset.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port addr  input  ADD_WIDTH  shared word address for all banks.
REQ-009 SHALL have port wdata  input  WIDTH*MEM_NUMBER  write data; lane i = bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-010 SHALL have port wr_en  input  1  write request.
REQ-011 SHALL have port wr_mask  input  MEM_NUMBER  per-bank write enable; bit i gates lane i.
REQ-012 SHALL have port rd_en  input  1  read request.
REQ-013 SHALL have port clr_req  input  1  start a software clear sweep.
REQ-014 SHALL have port rdata  output  WIDTH*MEM_NUMBER  registered read data.
REQ-015 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rdata.
REQ-016 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-017 SHALL have port err  output  1  one-cycle pulse on out-of-range or dropped request.

Function
REQ-018 SHALL implement MEM_NUMBER independent DEPTH x WIDTH arrays sharing addr, wr_en and rd_en.
REQ-019 SHALL, when idle with wr_en=1 and addr<DEPTH, write lane i of wdata into bank i at addr only where wr_mask[i]=1; unmasked banks keep contents.
REQ-020 SHALL, when idle with rd_en=1, register all bank words at addr into rdata on the same edge and assert rd_valid for the following cycle only (latency 1).
REQ-021 SHALL hold rdata at its last value whenever rd_valid is 0.
REQ-022 SHALL be read-first: simultaneous rd_en and wr_en to the same addr return the pre-write contents; the write still completes.
REQ-023 SHALL, for addr>=DEPTH, ignore the write, return all-zero rdata with rd_valid=1 if rd_en, and pulse err for one cycle.
REQ-024 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1, or on first edge after reset release when INIT_ON_RESET=1; CLEAR->IDLE after the word at DEPTH-1 is written.
REQ-025 SHALL, in CLEAR, write zero to all banks at an internal counter starting at 0 and incrementing by 1 per cycle, so the sweep lasts exactly DEPTH cycles.
REQ-026 SHALL assert busy in every CLEAR cycle and deassert it in the cycle the FSM returns to IDLE.
REQ-027 SHALL, while busy, drop wr_en and rd_en requests (no array change, rd_valid stays 0) and pulse err for each cycle with such a request.
REQ-028 SHALL ignore clr_req while busy (no restart, no err).
REQ-029 SHALL give a request that coincides with clr_req in IDLE priority to the clear (request dropped, err pulsed).

Reset
REQ-030 SHALL, while rst=1, force FSM=IDLE, clear counter=0, rdata=0, rd_valid=0, busy=0, err=0, asynchronously.
REQ-031 SHALL not reset array contents via rst; only the clear sweep zeroes them.
REQ-032 SHALL abort a sweep on rst assertion mid-clear and, when INIT_ON_RESET=1, restart it from address 0 after release.

Verification
REQ-033 SHALL cover: INIT_ON_RESET=1, release rst -> busy high exactly 128 cycles, then read addr 5 -> rdata=0, rd_valid one cycle later.
REQ-034 SHALL cover: write addr 3 wdata=0x0807060504030201 mask=0xFF, then mask=0x0F wdata=0xFFFFFFFFFFFFFFFF -> read addr 3 returns 0x08070605FFFFFFFF.
REQ-035 SHALL cover: same-cycle rd_en and wr_en at addr 3 with new data 0x11..11 -> rdata returns old value; next read returns 0x1111111111111111.
REQ-036 SHALL cover: DEPTH=100, ADD_WIDTH=7, read/write addr 120 -> err pulse, rdata=0, rd_valid=1, array unchanged.
REQ-037 SHALL cover: clr_req, then rd_en at sweep cycle 10 -> rd_valid stays 0, err pulses; rst at sweep cycle 50 -> outputs zero immediately, sweep restarts at address 0, full 128 cycles.
